// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit packed-BCD up/down counter (4 bits per digit, digit 0 = LSD).
//   State updates on the falling edge of clk. Per edge the priority is
//   clear > load > count.
//
//   Build option: define BCD_CNT_SAT_EN to saturate at all-9 / all-0 instead
//   of wrapping modulo 10^DIGITS. The wrap pulse then flags an attempted
//   overflow or underflow.
//
//   Ports
//     clk       clock; state updates on the falling edge
//     res       asynchronous active-low reset
//     en        count enable; clr and load act regardless of en
//     up        direction: 1 = increment, 0 = decrement
//     clr       synchronous clear to zero
//     load      synchronous parallel load of load_val
//     load_val  packed BCD load value; non-BCD digits are clamped to 9
//     q         registered packed BCD count
//     tc        combinational terminal count: en & (up ? q==all-9 : q==all-0)
//     wrap      registered one-cycle pulse on wrap (or saturation)
//     load_err  registered one-cycle pulse when a load carried a digit > 9
module bcd_updown_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic [W-1:0] clamp_val;
    logic         is_max;
    logic         is_min;
    logic         bad_digit;

    logic [W-1:0] q_next;
    logic         wrap_next;
    logic         load_err_next;

    // Per-digit ripple. is_max / is_min accumulate "all lower digits are 9 / 0",
    // which is exactly the condition for digit k to step.
    always_comb begin
        inc_val   = q;
        dec_val   = q;
        clamp_val = load_val;
        is_max    = 1'b1;
        is_min    = 1'b1;
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (is_max) begin
                inc_val[4*k +: 4] = (q[4*k +: 4] == 4'd9) ? 4'd0 : q[4*k +: 4] + 4'd1;
            end
            if (is_min) begin
                dec_val[4*k +: 4] = (q[4*k +: 4] == 4'd0) ? 4'd9 : q[4*k +: 4] - 4'd1;
            end
            is_max = is_max & (q[4*k +: 4] == 4'd9);
            is_min = is_min & (q[4*k +: 4] == 4'd0);
            if (load_val[4*k +: 4] > 4'd9) begin
                clamp_val[4*k +: 4] = 4'd9;
                bad_digit           = 1'b1;
            end
        end
    end

    // Cascade output: no registers between q/en/up and tc.
    assign tc = en & (up ? is_max : is_min);

    // Next-state selection with clear > load > count priority.
    always_comb begin
        q_next        = q;
        wrap_next     = 1'b0;
        load_err_next = 1'b0;
        if (clr) begin
            q_next = '0;
        end else if (load) begin
            q_next        = clamp_val;
            load_err_next = bad_digit;
        end else if (en) begin
            if (up) begin
                wrap_next = is_max;
`ifdef BCD_CNT_SAT_EN
                q_next    = is_max ? q : inc_val;
`else
                q_next    = inc_val;
`endif
            end else begin
                wrap_next = is_min;
`ifdef BCD_CNT_SAT_EN
                q_next    = is_min ? q : dec_val;
`else
                q_next    = dec_val;
`endif
            end
        end
    end

    // State register, falling-edge clocked.
    always_ff @(negedge clk or negedge res) begin
        if (!res) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            wrap     <= wrap_next;
            load_err <= load_err_next;
        end
    end

endmodule
